dmem_arbiter: RTL

Two-port arbiter that shares the single-port 256x8 data memory between the processor core's load/store path and a host port, which preloads operands (e.g. mem[0..4]) and drains results (mem[5..8]) around a program run. It sits between the core, the host loader and `data_mem`. A registered grant FSM serialises accesses, and each requester sees a req/ack handshake. The core is stalled while its request is pending.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 256x8 data memory between the core
// load/store path and the host loader port.
// A registered three-state grant FSM serialises the accesses. Each access
// takes one SERVE cycle followed by a return to IDLE, where both ports are
// arbitrated again.
// Tie policy: fixed priority (core wins) by default. Defining DMEM_ARB_RR_EN
// selects round-robin against the last port served.

module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

`ifdef DMEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_CORE = 2'd1,
        SERVE_HOST = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CORE = 1'b0,
        GRANT_HOST = 1'b1
    } grant_t;

    state_t          state_r;
    state_t          next_state_s;
    grant_t          last_grant_r;
    logic [DW-1:0]   core_rdata_r;
    logic [DW-1:0]   host_rdata_r;

    // On a tie the host wins only under round-robin, and only when the core was served last.
    function automatic logic host_wins_tie(input logic rr_en, input grant_t last);
        return rr_en & (last == GRANT_CORE);
    endfunction

    // Pick the next state: arbitrate in IDLE, always return from a SERVE state.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (core_req && host_req) begin
                    if (host_wins_tie(RR_EN, last_grant_r)) begin
                        next_state_s = SERVE_HOST;
                    end else begin
                        next_state_s = SERVE_CORE;
                    end
                end else if (core_req) begin
                    next_state_s = SERVE_CORE;
                end else if (host_req) begin
                    next_state_s = SERVE_HOST;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SERVE_CORE: next_state_s = IDLE;
            SERVE_HOST: next_state_s = IDLE;
            default:    next_state_s = IDLE;
        endcase
    end

    // Memory port mux. A reset arriving in a SERVE cycle suppresses the write.
    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = 1'b0;
        case (state_r)
            SERVE_CORE: begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_we    = core_we & ~Reset;
            end
            SERVE_HOST: begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                mem_we    = host_we & ~Reset;
            end
            default: begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_we    = 1'b0;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state. A reset arriving in a SERVE cycle blocks the ack.
    always_comb begin
        core_ack   = (state_r == SERVE_CORE) & ~Reset;
        host_ack   = (state_r == SERVE_HOST) & ~Reset;
        core_stall = core_req & ~core_ack;
        busy       = (state_r != IDLE);
        core_rdata = core_rdata_r;
        host_rdata = host_rdata_r;
    end

    // Grant FSM, last-grant tracking and read-data capture.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_HOST;
            core_rdata_r <= {DW{1'b0}};
            host_rdata_r <= {DW{1'b0}};
        end else begin
            state_r <= next_state_s;
            case (state_r)
                SERVE_CORE: begin
                    last_grant_r <= GRANT_CORE;
                    if (!core_we) begin
                        core_rdata_r <= mem_rdata;
                    end else begin
                        core_rdata_r <= core_rdata_r;
                    end
                end
                SERVE_HOST: begin
                    last_grant_r <= GRANT_HOST;
                    if (!host_we) begin
                        host_rdata_r <= mem_rdata;
                    end else begin
                        host_rdata_r <= host_rdata_r;
                    end
                end
                default: begin
                    last_grant_r <= last_grant_r;
                end
            endcase
        end
    end

endmodule
